// File: rtl/instruction_decoder.sv
// RV32I control decoder with a one-cycle registered control word (decode pipeline register).
// Optional DECODER_ILLEGAL_EN adds a registered illegal-encoding flag output.
module instruction_decoder (
  input  logic       Clk,
  input  logic       Clear,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       is_jump,
  output logic       is_jalr,
  output logic       is_branch,
  output logic       memwrite,
  output logic       regwrite,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [3:0] alu_control,
  output logic [1:0] result_src
`ifdef DECODER_ILLEGAL_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  typedef struct packed {
    logic       is_jump;
    logic       is_jalr;
    logic       is_branch;
    logic       memwrite;
    logic       regwrite;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [3:0] alu_control;
    logic [1:0] result_src;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  ctrl_t raw;
  logic  bad;
  logic  bad_q;

  // alt selects SUB on 000 and SRA on 101; ignored for other funct3 values.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (opcode)
      OP_R: begin
        raw.regwrite    = 1'b1;
        raw.alu_control = alu_op(funct3, funct7_5);
        bad = funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101);
      end
      OP_I: begin
        raw.regwrite    = 1'b1;
        raw.alu_srcb    = 2'b01;
        raw.alu_control = alu_op(funct3, (funct3 == 3'b101) && funct7_5);
        bad = (funct3 == 3'b001) && funct7_5;
      end
      OP_LOAD: begin
        raw.regwrite    = 1'b1;
        raw.alu_srcb    = 2'b01;
        raw.alu_control = ALU_ADD;
        raw.result_src  = 2'b01;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        raw.memwrite    = 1'b1;
        raw.alu_srcb    = 2'b01;
        raw.alu_control = ALU_ADD;
        bad = funct3 >= 3'b011;
      end
      OP_BRANCH: begin
        raw.is_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: raw.alu_control = ALU_SUB;
          3'b100, 3'b101: raw.alu_control = ALU_SLT;
          3'b110, 3'b111: raw.alu_control = ALU_SLTU;
          default:        bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        raw.is_jump     = 1'b1;
        raw.regwrite    = 1'b1;
        raw.alu_srca    = 1'b1;
        raw.alu_srcb    = 2'b01;
        raw.alu_control = ALU_ADD;
        raw.result_src  = 2'b10;
      end
      OP_JALR: begin
        raw.is_jump     = 1'b1;
        raw.is_jalr     = 1'b1;
        raw.regwrite    = 1'b1;
        raw.alu_srcb    = 2'b01;
        raw.alu_control = ALU_ADD;
        raw.result_src  = 2'b10;
        bad = funct3 != 3'b000;
      end
      OP_LUI: begin
        raw.regwrite    = 1'b1;
        raw.alu_srcb    = 2'b01;
        raw.alu_control = ALU_PASSB;
      end
      OP_AUIPC: begin
        raw.regwrite    = 1'b1;
        raw.alu_srca    = 1'b1;
        raw.alu_srcb    = 2'b01;
        raw.alu_control = ALU_ADD;
      end
      default: bad = 1'b1;
    endcase
    // Illegal encodings must never write state downstream.
    ctrl_d = bad ? '0 : raw;
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      ctrl_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      bad_q  <= bad;
    end
  end

  assign is_jump     = ctrl_q.is_jump;
  assign is_jalr     = ctrl_q.is_jalr;
  assign is_branch   = ctrl_q.is_branch;
  assign memwrite    = ctrl_q.memwrite;
  assign regwrite    = ctrl_q.regwrite;
  assign alu_srca    = ctrl_q.alu_srca;
  assign alu_srcb    = ctrl_q.alu_srcb;
  assign alu_control = ctrl_q.alu_control;
  assign result_src  = ctrl_q.result_src;

`ifdef DECODER_ILLEGAL_EN
  assign illegal = bad_q;
`else
  logic unused_bad;
  assign unused_bad = bad_q;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: instruction-level reference model with an expected queue,
// per-cycle compare, plus literal field checks on the documented example instructions.
module tb_instruction_decoder;

  logic       Clk = 1'b0;
  logic       Clear = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       is_jump, is_jalr, is_branch, memwrite, regwrite, alu_srca;
  logic [1:0] alu_srcb, result_src;
  logic [3:0] alu_control;
  logic       illegal_bit;

  int total = 0;
  int bad = 0;
  logic [14:0] exp_q[$];

  instruction_decoder dut (
    .Clk(Clk),
    .Clear(Clear),
    .opcode(opcode),
    .funct3(funct3),
    .funct7_5(funct7_5),
    .is_jump(is_jump),
    .is_jalr(is_jalr),
    .is_branch(is_branch),
    .memwrite(memwrite),
    .regwrite(regwrite),
    .alu_srca(alu_srca),
    .alu_srcb(alu_srcb),
    .alu_control(alu_control),
    .result_src(result_src)
`ifdef DECODER_ILLEGAL_EN
    ,
    .illegal(illegal_bit)
`endif
  );

`ifndef DECODER_ILLEGAL_EN
  assign illegal_bit = 1'b0;
`endif

  always #5 Clk = ~Clk;

  // Word layout: illegal, jump, jalr, branch, memwrite, regwrite, srca, srcb[2], alu[4], result[2]
  wire [14:0] act = {illegal_bit, is_jump, is_jalr, is_branch, memwrite, regwrite,
                     alu_srca, alu_srcb, alu_control, result_src};

  // Reference: classify the instruction, decide legality, then fill fields.
  function automatic logic [14:0] model(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic legal;
    logic j, jr, br, mw, rw, sa;
    logic [1:0] sb, rs;
    int alu;
    legal = 1'b1;
    {j, jr, br, mw, rw, sa} = '0;
    sb = 0; rs = 0; alu = 0;
    if (op == 7'h33) begin
      rw = 1; alu = alu_tab[f3];
      if (f7) begin
        if (f3 == 0 || f3 == 5) alu = alu + 1;
        else legal = 0;
      end
    end else if (op == 7'h13) begin
      rw = 1; sb = 1; alu = alu_tab[f3];
      if (f3 == 5 && f7) alu = alu + 1;
      if (f3 == 1 && f7) legal = 0;
    end else if (op == 7'h03) begin
      rw = 1; sb = 1; rs = 1;
      legal = (f3 inside {0, 1, 2, 4, 5});
    end else if (op == 7'h23) begin
      mw = 1; sb = 1;
      legal = (f3 < 3);
    end else if (op == 7'h63) begin
      br = 1;
      alu = (f3 < 2) ? 1 : (f3 < 4) ? 0 : (f3 < 6) ? 3 : 4;
      legal = !(f3 == 2 || f3 == 3);
    end else if (op == 7'h6F) begin
      j = 1; rw = 1; sa = 1; sb = 1; rs = 2;
    end else if (op == 7'h67) begin
      j = 1; jr = 1; rw = 1; sb = 1; rs = 2;
      legal = (f3 == 0);
    end else if (op == 7'h37) begin
      rw = 1; sb = 1; alu = 10;
    end else if (op == 7'h17) begin
      rw = 1; sa = 1; sb = 1;
    end else begin
      legal = 0;
    end
    if (!legal) return 15'h4000;
    return {1'b0, j, jr, br, mw, rw, sa, sb, alu[3:0], rs};
  endfunction

  task automatic drive(input logic clr, input logic [6:0] op, input logic [2:0] f3, input logic f7);
    logic [14:0] e;
    @(negedge Clk);
    Clear = clr; opcode = op; funct3 = f3; funct7_5 = f7;
    e = clr ? 15'h0 : model(op, f3, f7);
`ifndef DECODER_ILLEGAL_EN
    e[14] = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic lit(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Per-cycle compare against the model queue.
  always @(posedge Clk) begin
    logic [14:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL word @%0t: got %b expected %b", $time, act, e);
      end
    end
  end

  task automatic settle();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    // Model pins: hand-computed words.
    lit("model_add",  model(7'h33, 3'd0, 1'b0), 15'b000001000000000);
    lit("model_sub",  model(7'h33, 3'd0, 1'b1), 15'b000001000000100);
    lit("model_lui",  model(7'h37, 3'd0, 1'b0), 15'b000001001101000);
    lit("model_bad",  model(7'h7F, 3'd0, 1'b0), 15'b100000000000000);

    drive(1'b1, 7'b0110011, 3'd0, 1'b0); settle();
    lit("clear_word", act, 0);

    drive(1'b0, 7'b0110011, 3'b000, 1'b0); settle();
    lit("add_regwrite", regwrite, 1);
    lit("add_alu", alu_control, 4'b0000);
    lit("add_srcb", alu_srcb, 0);
    lit("add_result", result_src, 0);

    drive(1'b0, 7'b0110011, 3'b000, 1'b1); settle();
    lit("sub_alu", alu_control, 4'b0001);

    drive(1'b0, 7'b0010011, 3'b000, 1'b1); settle();
    lit("addi_alu", alu_control, 4'b0000);
    lit("addi_srcb", alu_srcb, 1);

    drive(1'b0, 7'b0000011, 3'b010, 1'b0); settle();
    lit("lw_result", result_src, 1);
    lit("lw_regwrite", regwrite, 1);

    drive(1'b0, 7'b0100011, 3'b010, 1'b0); settle();
    lit("sw_memwrite", memwrite, 1);
    lit("sw_regwrite", regwrite, 0);
    lit("sw_srcb", alu_srcb, 1);

    drive(1'b0, 7'b1100011, 3'b000, 1'b0); settle();
    lit("beq_branch", is_branch, 1);
    lit("beq_alu", alu_control, 4'b0001);

    drive(1'b0, 7'b1101111, 3'b000, 1'b0); settle();
    lit("jal_jump", is_jump, 1);
    lit("jal_jalr", is_jalr, 0);
    lit("jal_srca", alu_srca, 1);
    lit("jal_result", result_src, 2);

    drive(1'b0, 7'b1100111, 3'b000, 1'b0); settle();
    lit("jalr_jump", is_jump, 1);
    lit("jalr_jalr", is_jalr, 1);
    lit("jalr_srca", alu_srca, 0);

    drive(1'b0, 7'b1111111, 3'b000, 1'b0); settle();
    lit("badop_ctrl", act[13:0], 0);
`ifdef DECODER_ILLEGAL_EN
    lit("badop_illegal", illegal_bit, 1);
`endif

    drive(1'b0, 7'b1100011, 3'b010, 1'b0); settle();
    lit("badbr_ctrl", act[13:0], 0);
`ifdef DECODER_ILLEGAL_EN
    lit("badbr_illegal", illegal_bit, 1);
`endif

    // Clear overrides a valid instruction at the same edge.
    drive(1'b0, 7'b0110111, 3'b000, 1'b0);
    drive(1'b1, 7'b1101111, 3'b000, 1'b0); settle();
    lit("clear_override", act, 0);

    // Sweep every listed opcode plus one unlisted one across all funct3/funct7_5.
    begin
      logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};
      for (int o = 0; o < 10; o++)
        for (int k = 0; k < 16; k++)
          drive(1'b0, ops[o], k[2:0], k[3]);
    end

    @(posedge Clk);
    #3;
    lit("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

RV32I control decoder: maps opcode, funct3 and funct7 bit 5 to the datapath control word (jump/branch flags, write enables, ALU operand selects, ALU operation, result select). The control word is registered once, forming the decode-stage pipeline register between instruction fetch and the execute datapath.

## Interface
- No parameters.
- Clk  input  1  rising-edge clock
- Clear  input  1  reset; synchronous, active-high
- opcode  input  7  instruction[6:0]
- funct3  input  3  instruction[14:12]
- funct7_5  input  1  instruction[30]
- is_jump  output  1  JAL or JALR
- is_jalr  output  1  JALR only
- is_branch  output  1  conditional branch
- memwrite  output  1  data-memory write enable
- regwrite  output  1  register-file write enable
- alu_srca  output  1  0 = rs1, 1 = PC
- alu_srcb  output  2  00 = rs2, 01 = immediate, 10 = constant 4, 11 unused
- alu_control  output  4  ALU operation
- result_src  output  2  00 = ALU, 01 = memory read data, 10 = PC+4, 11 unused
- illegal  output  1  only with DECODER_ILLEGAL_EN

## Operation
- alu_control codes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASSB; 1011–1111 unused.
- ALU funct3 map: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- R-type (0110011): regwrite=1, srca=0, srcb=00, result=00; funct7_5 selects SUB (on 000) and SRA (on 101).
- I-ALU (0010011): same as R-type but srcb=01; funct3=000 is always ADD (funct7_5 ignored); 101 uses funct7_5 for SRA.
- Load (0000011): regwrite=1, srcb=01, ADD, result=01.
- Store (0100011): memwrite=1, regwrite=0, srcb=01, ADD.
- Branch (1100011): is_branch=1, srcb=00, regwrite=0; 000/001 SUB, 100/101 SLT, 110/111 SLTU.
- JAL (1101111): is_jump=1, regwrite=1, srca=1, srcb=01, ADD, result=10.
- JALR (1100111): is_jump=1, is_jalr=1, regwrite=1, srca=0, srcb=01, ADD, result=10.
- LUI (0110111): regwrite=1, srcb=01, PASSB, result=00.
- AUIPC (0010111): regwrite=1, srca=1, srcb=01, ADD, result=00.
- Any field not named for an instruction is 0.
- Illegal: unlisted opcode; branch funct3 010/011; load funct3 011/110/111; store funct3 ≥ 011; JALR funct3 ≠ 000; R-type funct7_5=1 with funct3 other than 000/101; I-ALU 001 with funct7_5=1.
- Illegal encodings drive the all-zero control word (no register write, no memory write).

## Timing
- Decode is combinational; all outputs are registered on the rising edge of Clk.
- Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- Clear=1 at an edge forces every output, including illegal, to 0.
- Clear overrides the inputs sampled at the same edge.
- Outputs are undefined until the first Clear edge.
- The register updates every cycle; there is no enable or stall input.

## Configuration
- DECODER_ILLEGAL_EN defined: the illegal output port exists and is registered; it is 1 for each illegal encoding, while the control word is still all-zero.
- DECODER_ILLEGAL_EN undefined: the port is absent; illegal encodings still yield the all-zero control word.

## Test plan
- Clear=1 for one edge with opcode=0110011 applied -> every output is 0 after that edge.
- ADD: opcode=0110011, funct3=000, funct7_5=0 -> after 1 edge, regwrite=1, alu_control=0000, alu_srcb=00, result_src=00. Same with funct7_5=1 -> alu_control=0001.
- ADDI: opcode=0010011, funct3=000, funct7_5=1 -> alu_control=0000, alu_srcb=01. LW: opcode=0000011, funct3=010 -> result_src=01, regwrite=1.
- SW: opcode=0100011, funct3=010 -> memwrite=1, regwrite=0, alu_srcb=01. BEQ: opcode=1100011, funct3=000 -> is_branch=1, alu_control=0001.
- JAL: opcode=1101111 -> is_jump=1, is_jalr=0, alu_srca=1, result_src=10. JALR: opcode=1100111, funct3=000 -> is_jump=1, is_jalr=1, alu_srca=0.
- opcode=1111111, then branch funct3=010 -> all-zero control word; illegal=1 when DECODER_ILLEGAL_EN is defined.
